// File: rtl/mem_access_unit.sv
// Memory access unit: arbitrates instruction fetch against data/writeback
// requests onto a single-port synchronous RAM, returning results as valid pulses.

module mem_access_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned PC_WIDTH   = 8,
   parameter int unsigned RD_LATENCY = 1,
   parameter logic [3:0]  OP_LDR     = 4'h9,
   parameter logic [3:0]  OP_STR     = 4'hA
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  fetch_req,
   input  logic [PC_WIDTH-1:0]   pc_instr_access,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic                  instr_valid,
   input  logic                  mem_req,
   input  logic [3:0]            op_code,
   input  logic [DATA_WIDTH-1:0] src1,
   input  logic [DATA_WIDTH-1:0] src2,
   input  logic [DATA_WIDTH-1:0] store_data,
   input  logic [DATA_WIDTH-1:0] alu_result,
   output logic [DATA_WIDTH-1:0] result_out,
   output logic                  result_valid,
   output logic                  busy,
   output logic                  ram_en,
   output logic                  ram_rw_flag,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_out,
   input  logic [DATA_WIDTH-1:0] ram_data_in
);

   // Counter is wide enough for the full legal latency range 1..4
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  is_fetch_q, is_fetch_d;
   logic                  is_store_q, is_store_d;
   logic                  ram_en_q, ram_en_d;
   logic                  ram_rw_q, ram_rw_d;
   logic [ADDR_WIDTH-1:0] ram_address_q, ram_address_d;
   logic [DATA_WIDTH-1:0] ram_data_out_q, ram_data_out_d;
   logic [DATA_WIDTH-1:0] result_out_q, result_out_d;
   logic                  result_valid_q, result_valid_d;
   logic [DATA_WIDTH-1:0] instr_data_q, instr_data_d;
   logic                  instr_valid_q, instr_valid_d;

   // State and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         is_fetch_q     <= 1'b0;
         is_store_q     <= 1'b0;
         ram_en_q       <= 1'b0;
         ram_rw_q       <= 1'b0;
         ram_address_q  <= '0;
         ram_data_out_q <= '0;
         result_out_q   <= '0;
         result_valid_q <= 1'b0;
         instr_data_q   <= '0;
         instr_valid_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         is_fetch_q     <= is_fetch_d;
         is_store_q     <= is_store_d;
         ram_en_q       <= ram_en_d;
         ram_rw_q       <= ram_rw_d;
         ram_address_q  <= ram_address_d;
         ram_data_out_q <= ram_data_out_d;
         result_out_q   <= result_out_d;
         result_valid_q <= result_valid_d;
         instr_data_q   <= instr_data_d;
         instr_valid_q  <= instr_valid_d;
      end
   end

   // Next-state and registered-output logic; pulses and strobes default low
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      is_fetch_d     = is_fetch_q;
      is_store_d     = is_store_q;
      ram_en_d       = 1'b0;
      ram_rw_d       = 1'b0;
      ram_address_d  = ram_address_q;
      ram_data_out_d = ram_data_out_q;
      result_out_d   = result_out_q;
      result_valid_d = 1'b0;
      instr_data_d   = instr_data_q;
      instr_valid_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (mem_req) begin
               is_fetch_d = 1'b0;
               is_store_d = (op_code == OP_STR);
               if ((op_code == OP_LDR) || (op_code == OP_STR)) begin
                  state_d       = S_ISSUE;
                  ram_en_d      = 1'b1;
                  ram_rw_d      = (op_code == OP_STR);
                  ram_address_d = ADDR_WIDTH'(src1 + src2);
                  if (op_code == OP_STR) begin
                     ram_data_out_d = store_data;
                  end
               end else begin
                  result_out_d   = alu_result;
                  result_valid_d = 1'b1;
               end
            end else if (fetch_req) begin
               is_fetch_d    = 1'b1;
               is_store_d    = 1'b0;
               state_d       = S_ISSUE;
               ram_en_d      = 1'b1;
               ram_address_d = ADDR_WIDTH'(pc_instr_access);
            end
         end
         S_ISSUE: begin
            if (is_store_q) begin
               state_d        = S_IDLE;
               result_valid_d = 1'b1;
            end else begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end
         end
         S_WAIT: begin
            // Read data is valid in the last wait cycle; capture and pulse on return to idle
            if (cnt_q == CNT_W'(RD_LATENCY - 1)) begin
               state_d = S_IDLE;
               if (is_fetch_q) begin
                  instr_data_d  = ram_data_in;
                  instr_valid_d = 1'b1;
               end else begin
                  result_out_d   = ram_data_in;
                  result_valid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy         = (state_q != S_IDLE);
   assign ram_en       = ram_en_q;
   assign ram_rw_flag  = ram_rw_q;
   assign ram_address  = ram_address_q;
   assign ram_data_out = ram_data_out_q;
   assign result_out   = result_out_q;
   assign result_valid = result_valid_q;
   assign instr_data   = instr_data_q;
   assign instr_valid  = instr_valid_q;

endmodule
